// File: rtl/seq_detect_pkg.sv
// Shared types and width helpers for the run-of-ones detection scheduler.
package seq_detect_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } state_e;

  function automatic int id_w(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

  function automatic int bit_w(input int frame_len);
    return (frame_len > 1) ? $clog2(frame_len) : 1;
  endfunction

  function automatic int run_w(input int run_len);
    return $clog2(run_len + 1);
  endfunction

  function automatic int mcnt_w(input int frame_len, input int run_len);
    return $clog2(frame_len / run_len + 1) + 1;
  endfunction

endpackage

// File: rtl/seq_detect_scheduler_if.sv
// Requester/status bundle between the serial sources and the scheduler.
// match_cnt exists only when SEQ_DETECT_MATCH_COUNT_EN is defined.
interface seq_detect_scheduler_if
  import seq_detect_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int FRAME_LEN = 16,
  parameter int RUN_LEN   = 3
) ();

  localparam int ID_W = id_w(N_REQ);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] x;
  logic [N_REQ-1:0] gnt;
  logic             busy;
  logic             done;
  logic [ID_W-1:0]  done_id;
  logic             hit;
  logic             abort;

`ifdef SEQ_DETECT_MATCH_COUNT_EN
  localparam int MCNT_W = mcnt_w(FRAME_LEN, RUN_LEN);
  logic [MCNT_W-1:0] match_cnt;

  modport master (output req, x, input gnt, busy, done, done_id, hit, abort, match_cnt);
  modport slave  (input req, x, output gnt, busy, done, done_id, hit, abort, match_cnt);
`else
  modport master (output req, x, input gnt, busy, done, done_id, hit, abort);
  modport slave  (input req, x, output gnt, busy, done, done_id, hit, abort);
`endif

endinterface

// File: rtl/seq_run_detector.sv
// Saturating counter of consecutive ones; complete flags the step that reaches RUN_LEN.
module seq_run_detector
  import seq_detect_pkg::*;
#(
  parameter  int RUN_LEN = 3,
  localparam int CNT_W   = run_w(RUN_LEN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             x,
  output logic [CNT_W-1:0] count,
  output logic             complete
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] PRE  = CNT_W'(RUN_LEN - 1);

  logic [CNT_W-1:0] r_cnt;

  // Holding at FULL keeps a long run of ones a single event.
  assign complete = en & x & (r_cnt == PRE);
  assign count    = r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      if (!x)                r_cnt <= '0;
      else if (r_cnt != FULL) r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detect_scheduler.sv
// Round-robin scheduler sharing one run-of-ones detector across N_REQ serial lines.
// Optional per-frame completion count: define SEQ_DETECT_MATCH_COUNT_EN.
module seq_detect_scheduler
  import seq_detect_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int FRAME_LEN = 16,
  parameter int RUN_LEN   = 3
) (
  input logic                   clk,
  input logic                   reset,
  seq_detect_scheduler_if.slave bus
);

  localparam int ID_W      = id_w(N_REQ);
  localparam int BIT_W     = bit_w(FRAME_LEN);
  localparam int RUN_CNT_W = run_w(RUN_LEN);

  state_e           r_state, w_state_nxt;
  logic [ID_W-1:0]  r_winner, r_ptr, w_pick, r_done_id;
  logic [BIT_W-1:0] r_bitcnt;
  logic [N_REQ-1:0] r_gnt;
  logic             r_sticky, r_done, r_hit, r_abort;
  logic             w_any, w_req_win, w_x_win, w_last, w_complete, w_det_clr, w_det_en;
  logic [RUN_CNT_W-1:0] w_run_cnt;

  // First requester at or above the pointer, wrapping.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_any && bus.req[(int'(r_ptr) + k) % N_REQ]) begin
        w_any  = 1'b1;
        w_pick = ID_W'((int'(r_ptr) + k) % N_REQ);
      end
    end
  end

  assign w_req_win = bus.req[r_winner];
  assign w_x_win   = bus.x[r_winner];
  assign w_last    = (r_bitcnt == BIT_W'(FRAME_LEN - 1));
  assign w_det_clr = (r_state == IDLE);
  assign w_det_en  = (r_state == RUN) && w_req_win;

  seq_run_detector #(.RUN_LEN(RUN_LEN)) u_det (
    .clk      (clk),
    .reset    (reset),
    .clr      (w_det_clr),
    .en       (w_det_en),
    .x        (w_x_win),
    .count    (w_run_cnt),
    .complete (w_complete)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_nxt = RUN;
      RUN:     if (!w_req_win || w_last) w_state_nxt = REPORT;
      REPORT:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_winner  <= '0;
      r_ptr     <= '0;
      r_bitcnt  <= '0;
      r_sticky  <= 1'b0;
      r_gnt     <= '0;
      r_done    <= 1'b0;
      r_done_id <= '0;
      r_hit     <= 1'b0;
      r_abort   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (w_any) begin
            r_winner <= w_pick;
            r_gnt    <= N_REQ'(1) << w_pick;
            r_bitcnt <= '0;
            r_sticky <= 1'b0;
          end
        end
        RUN: begin
          // A dropped request ends the frame without counting this edge's bit.
          if (!w_req_win) begin
            r_gnt     <= '0;
            r_done    <= 1'b1;
            r_done_id <= r_winner;
            r_hit     <= 1'b0;
            r_abort   <= 1'b1;
          end else begin
            r_bitcnt <= r_bitcnt + 1'b1;
            if (w_complete) r_sticky <= 1'b1;
            if (w_last) begin
              r_gnt     <= '0;
              r_done    <= 1'b1;
              r_done_id <= r_winner;
              r_hit     <= r_sticky | w_complete;
              r_abort   <= 1'b0;
            end
          end
        end
        REPORT: begin
          r_done <= 1'b0;
          r_ptr  <= (r_winner == ID_W'(N_REQ - 1)) ? '0 : r_winner + 1'b1;
        end
        default: r_done <= 1'b0;
      endcase
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.busy    = (r_state != IDLE);
  assign bus.done    = r_done;
  assign bus.done_id = r_done_id;
  assign bus.hit     = r_hit;
  assign bus.abort   = r_abort;

`ifdef SEQ_DETECT_MATCH_COUNT_EN
  localparam int MCNT_W = mcnt_w(FRAME_LEN, RUN_LEN);
  logic [MCNT_W-1:0] r_mcnt_acc, r_match_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mcnt_acc  <= '0;
      r_match_cnt <= '0;
    end else if (r_state == IDLE) begin
      r_mcnt_acc <= '0;
    end else if (r_state == RUN) begin
      if (!w_req_win) begin
        r_match_cnt <= '0;
      end else begin
        r_mcnt_acc <= r_mcnt_acc + MCNT_W'(w_complete);
        if (w_last) r_match_cnt <= r_mcnt_acc + MCNT_W'(w_complete);
      end
    end
  end

  assign bus.match_cnt = r_match_cnt;
`endif

  ap_run_cnt_range: assert property (@(posedge clk) disable iff (!reset)
    w_run_cnt <= RUN_CNT_W'(RUN_LEN));

endmodule

// File: doc/seq_detect_scheduler.md
Name: seq_detect_scheduler

Overview:
- Shares one serial run-of-ones detector between N_REQ requesters, each driving its own serial bit line.
- A round-robin arbiter grants one requester per frame.
- The FSM then steps the shared detector over exactly FRAME_LEN bits of that requester's line and reports a per-frame hit with the winner's id.
- Sits between the serial bit sources and the status/control logic.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- FRAME_LEN, 16, bits examined per grant (2..256).
- RUN_LEN, 3, consecutive ones that constitute a detection (1..FRAME_LEN).

Ports:
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- req  input  N_REQ  per-requester frame request; must be held for the whole frame.
- x  input  N_REQ  per-requester serial data bit.
- gnt  output  N_REQ  one-hot grant, registered; high for the whole frame.
- busy  output  1  high in RUN and REPORT.
- done  output  1  one-cycle pulse in REPORT.
- done_id  output  ID_W  index of the finished requester; valid when done=1. ID_W = max(1, clog2(N_REQ)).
- hit  output  1  run of RUN_LEN ones occurred in the frame; valid when done=1.
- abort  output  1  frame ended early because req dropped; valid when done=1.

Behaviour:
Reset (reset=0): state IDLE, gnt=0, busy=0, done=0, done_id=0, hit=0, abort=0, rr pointer=0, bit counter=0, run counter=0, sticky hit=0.

FSM states and transitions:
- IDLE: if req!=0, the winner is the first set req at or above the pointer, wrapping. Next cycle RUN with gnt=onehot(winner), bit counter=0, run counter=0, sticky=0. If req=0, stay.
- RUN: each edge samples x[winner] into the run detector and increments the bit counter.
  - If req[winner]=0 at an edge: go to REPORT with abort=1, hit=0. That edge's x is not counted.
  - Else, on the edge where the bit counter = FRAME_LEN-1: go to REPORT with abort=0. hit = sticky OR (run completes on this final bit).
- REPORT: lasts one cycle.
  - done=1, gnt=0, done_id=winner.
  - pointer <= (winner+1) mod N_REQ.
  - Next IDLE. Requests are not evaluated in REPORT.
  - Minimum grant-to-grant spacing is FRAME_LEN+2 cycles.

Run detector:
- Counter of consecutive ones, width clog2(RUN_LEN+1).
- x=1: increment, saturating at RUN_LEN. x=0: clear to 0.
- A completion event is the transition of the counter to RUN_LEN. Completion sets sticky.
- Counter holds RUN_LEN while ones continue, so a long run is one event.

Latency:
- req rising in IDLE at cycle t: gnt high cycles t+1 .. t+FRAME_LEN, done at t+FRAME_LEN+1.

Other rules:
- req changes for non-granted requesters during RUN are ignored.
- x of non-granted lines is ignored.
- reset asserted mid-RUN or mid-REPORT: gnt drops and done drops immediately; no report is produced; pointer returns to 0.

Optional Feature:
- Macro: SEQ_DETECT_MATCH_COUNT_EN.
- Defined: adds output match_cnt, width clog2(FRAME_LEN/RUN_LEN+1)+1.
  - Counts completion events in the frame, including one on the final bit.
  - Valid with done; 0 on abort; reset value 0.
- Undefined: port and counter are absent; hit is the only result.

Decomposition:
- Package seq_detect_pkg: state enum (IDLE, RUN, REPORT), plus width helper functions for ID_W and the counter widths.
- One sub-module, seq_run_detector (clk, reset, clr, en, x, count, complete). It holds the saturating run counter and flags completion combinationally.
- Arbitration and the FSM stay in the top.

Test Plan:
1. req=4'b0100; x[2] is 0 for bits 0-12 and 1 for bits 13-15 -> gnt=4'b0100 for 16 cycles, then done=1, done_id=2, hit=1 (final-bit completion), abort=0.
2. All four req held high from reset release -> done_id sequence 0,1,2,3,0; grants spaced 18 cycles apart.
3. req[1] single; x[1]=1,1,0,1,1,0 repeating -> hit=0. Repeat with x[1] all ones -> hit=1; match_cnt=1 when SEQ_DETECT_MATCH_COUNT_EN is defined.
4. req[3] granted, then req[3] dropped after 5 sampled bits -> done=1, done_id=3, abort=1, hit=0; next grant goes to 0 if req[0] is set.
5. reset pulled low at bit 8 of a frame for requester 2 -> gnt=0 the same cycle, no done. After release with req=4'b0110, the first grant is 1 because the pointer reset to 0.
6. With the count feature, x=1,1,1,0,1,1,1,0,1,1,1,0,1,1,1,0 and RUN_LEN=3 -> match_cnt=4, hit=1.
